// File: rtl/tpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tpu_pkg                                                         |
// | Purpose  : Shared TPU datapath constants, lane type and feeder FSM states. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package tpu_pkg;

    localparam int LANES  = 32;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;

    typedef logic [DATA_W-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : skew_delay_line                                                 |
// | Purpose  : DEPTH-stage data+valid shift register with shift enable.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module skew_delay_line
    import tpu_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_en,
    input  lane_t i_data,
    input  logic  i_valid,
    output lane_t o_data,
    output logic  o_valid,
    output logic  o_any_valid
);

    lane_t            r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
            r_valid <= '0;
        end else if (i_en) begin
            r_data[0]  <= i_data;
            r_valid[0] <= i_valid;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k]  <= r_data[k-1];
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    assign o_data      = r_data[DEPTH-1];
    assign o_valid     = r_valid[DEPTH-1];
    // Lets the owner know when the whole line has emptied out.
    assign o_any_valid = |r_valid;

endmodule
`default_nettype wire

// File: rtl/ub_skew_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ub_skew_feeder                                                  |
// | Purpose  : Streams unified-buffer rows into a diagonal (skewed) wavefront. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ub_skew_feeder
    import tpu_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [ADDR_W-1:0]       base_addr_i,
    input  logic [ADDR_W:0]         num_rows_i,
    input  logic                    stall_i,
    output logic                    ub_rd_o,
    output logic [ADDR_W-1:0]       ub_addr_rd_o,
    input  logic [LANES*DATA_W-1:0] ub_data_i,
    output logic [LANES*DATA_W-1:0] array_data_o,
    output logic [LANES-1:0]        array_valid_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam logic [ADDR_W:0] c_one = {{ADDR_W{1'b0}}, 1'b1};

    feeder_state_e     r_state;
    feeder_state_e     w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_num_rows;
    logic [ADDR_W:0]   r_row_cnt;
    logic              r_rd_pending;
    logic              r_zero_done;
    logic              w_accept;
    logic              w_zero_start;
    logic              w_drain_done;
    logic              w_last_row;
    logic              w_shift_en;
    logic              w_pipe_active;
    logic [LANES-1:0]  w_lane_busy;

    assign w_shift_en    = ~stall_i;
    assign w_last_row    = (r_row_cnt == (r_num_rows - c_one));
    assign w_pipe_active = r_rd_pending | (|w_lane_busy);

    always_comb begin
        w_state_nxt  = r_state;
        ub_rd_o      = 1'b0;
        w_accept     = 1'b0;
        w_zero_start = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i && !stall_i) begin
                    if (num_rows_i != '0) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_zero_start = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!stall_i) begin
                    ub_rd_o = 1'b1;
                    if (w_last_row) begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!stall_i && !w_pipe_active) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_num_rows   <= '0;
            r_row_cnt    <= '0;
            r_rd_pending <= 1'b0;
            r_zero_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_base     <= base_addr_i;
                r_num_rows <= num_rows_i;
                r_row_cnt  <= '0;
            end else if (ub_rd_o) begin
                r_row_cnt <= r_row_cnt + c_one;
            end
            // A stalled cycle must not lose the tag for data the buffer is holding.
            if (!stall_i) begin
                r_rd_pending <= ub_rd_o;
                r_zero_done  <= w_zero_start;
            end
        end
    end

    assign ub_addr_rd_o = r_base + r_row_cnt[ADDR_W-1:0];
    assign done_o       = w_drain_done | (r_zero_done & ~stall_i);
    assign busy_o       = (r_state != IDLE) & ~w_drain_done;

    // Lane i sees i+1 registers; untagged rows enter as zero so idle lanes read 0.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            lane_t w_cap;
            assign w_cap = r_rd_pending ? ub_data_i[gi*DATA_W +: DATA_W] : '0;

            skew_delay_line #(
                .DEPTH (gi + 1)
            ) u_delay (
                .clk         (clk_i),
                .rst_n       (rst_ni),
                .i_en        (w_shift_en),
                .i_data      (w_cap),
                .i_valid     (r_rd_pending),
                .o_data      (array_data_o[gi*DATA_W +: DATA_W]),
                .o_valid     (array_valid_o[gi]),
                .o_any_valid (w_lane_busy[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ub_skew_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ub_skew_feeder                                               |
// | Purpose  : Scoreboard bench for ub_skew_feeder with a unified-buffer model.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ub_skew_feeder;
    import tpu_pkg::*;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
    } rd_exp_t;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] val;
    } ln_exp_t;

    logic                    clk = 1'b0;
    logic                    rst_ni;
    logic                    start_i;
    logic [ADDR_W-1:0]       base_addr_i;
    logic [ADDR_W:0]         num_rows_i;
    logic                    stall_i;
    logic                    ub_rd_o;
    logic [ADDR_W-1:0]       ub_addr_rd_o;
    logic [LANES*DATA_W-1:0] ub_data_i = '0;
    logic [LANES*DATA_W-1:0] array_data_o;
    logic [LANES-1:0]        array_valid_o;
    logic                    busy_o;
    logic                    done_o;

    logic [LANES*DATA_W-1:0] mem [4096];

    rd_exp_t rd_q[$];
    ln_exp_t lane_q[LANES][$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int st0      = 1000;
    int st1      = -1;
    int exp_done = -1;
    int busy_hi  = 0;
    int done_cnt = 0;
    bit mon_en   = 1'b0;

    ub_skew_feeder dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .num_rows_i    (num_rows_i),
        .stall_i       (stall_i),
        .ub_rd_o       (ub_rd_o),
        .ub_addr_rd_o  (ub_addr_rd_o),
        .ub_data_i     (ub_data_i),
        .array_data_o  (array_data_o),
        .array_valid_o (array_valid_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Unified buffer: registered read, output held while not reading.
    always @(posedge clk) if (ub_rd_o) ub_data_i <= mem[ub_addr_rd_o];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_st(input int c);
        return (c >= st0) && (c <= st1);
    endfunction

    // Cycle that follows m non-stalled cycles counted from c0.
    function automatic int skip_ns(input int c0, input int m);
        int c;
        int left;
        c = c0;
        left = m;
        while (left > 0) begin
            if (!is_st(c)) left--;
            c++;
        end
        return c;
    endfunction

    task automatic monitor_cycle();
        int rel;
        rd_exp_t re;
        ln_exp_t le;
        logic [LANES*DATA_W-1:0] idle_bits;
        rel = cyc - t0;
        if (ub_rd_o) begin
            if (rd_q.size() == 0) begin
                chk("rd_unexpected", 64'(ub_rd_o), 64'd0);
            end else begin
                re = rd_q.pop_front();
                chk("rd_addr", 64'(ub_addr_rd_o), 64'(re.addr));
                chk("rd_cycle", 64'(rel), 64'(re.cyc));
            end
        end else if (rd_q.size() > 0 && rd_q[0].cyc == rel) begin
            chk("rd_missing", 64'(ub_rd_o), 64'd1);
            re = rd_q.pop_front();
        end
        for (int i = 0; i < LANES; i++) begin
            if (array_valid_o[i]) begin
                if (lane_q[i].size() == 0) begin
                    chk("lane_unexpected_valid", 64'(array_valid_o[i]), 64'd0);
                end else begin
                    le = lane_q[i].pop_front();
                    chk("lane_data", 64'(array_data_o[i*DATA_W +: DATA_W]), 64'(le.val));
                    chk("lane_cycle", 64'(rel), 64'(le.cyc));
                end
            end else if (lane_q[i].size() > 0 && lane_q[i][0].cyc == rel) begin
                chk("lane_missing_valid", 64'(array_valid_o[i]), 64'd1);
                le = lane_q[i].pop_front();
            end
            idle_bits[i*DATA_W +: DATA_W] = array_valid_o[i] ? '0 : array_data_o[i*DATA_W +: DATA_W];
        end
        chk("idle_lane_zero", 64'(|idle_bits), 64'd0);
        chk("busy", 64'(busy_o), 64'((rel >= 1) && (rel <= busy_hi)));
        if (done_o) begin
            done_cnt++;
            chk("done_cycle", 64'(rel), 64'(exp_done));
        end
    endtask

    always @(negedge clk) if (mon_en) monitor_cycle();

    // One command: push the expected reads/lanes, then drive stall/extra start per cycle.
    task automatic run(input int base, input int n, input int s0, input int s1,
                       input int ign, input int abort_at);
        int c;
        int last;
        logic [ADDR_W-1:0] a;
        @(posedge clk);
        #1;
        t0 = cyc;
        st0 = s0;
        st1 = s1;
        start_i = 1'b1;
        base_addr_i = base[ADDR_W-1:0];
        num_rows_i = n[ADDR_W:0];
        c = 1;
        last = 0;
        for (int k = 0; k < n; k++) begin
            while (is_st(c)) c++;
            a = ADDR_W'((base + k) % 4096);
            rd_q.push_back('{cyc: c, addr: a});
            for (int i = 0; i < LANES; i++) begin
                last = skip_ns(c + 1, i + 1);
                lane_q[i].push_back('{cyc: last, val: mem[a][i*DATA_W +: DATA_W]});
            end
            c++;
        end
        if (n == 0) begin
            exp_done = 1;
            busy_hi = 0;
        end else begin
            c = last + 1;
            while (is_st(c)) c++;
            exp_done = c;
            busy_hi = c - 1;
        end
        done_cnt = 0;
        for (int r = 1; r <= exp_done + 5; r++) begin
            @(posedge clk);
            #1;
            start_i = (r == ign);
            if (r == ign) begin
                base_addr_i = 12'd77;
                num_rows_i = 13'd9;
            end
            stall_i = is_st(r);
            if (r == abort_at) begin
                mon_en = 1'b0;
                rst_ni = 1'b0;
                #1;
                chk("abort_outputs_zero",
                    64'({ub_rd_o, busy_o, done_o, |ub_addr_rd_o, |array_valid_o, |array_data_o}),
                    64'd0);
                rd_q.delete();
                for (int i = 0; i < LANES; i++) lane_q[i].delete();
                exp_done = -1;
                busy_hi = 0;
                break;
            end
        end
        start_i = 1'b0;
        stall_i = 1'b0;
        if (abort_at < 0) begin
            chk("done_count", 64'(done_cnt), 64'd1);
            chk("reads_left", 64'(rd_q.size()), 64'd0);
            c = 0;
            for (int i = 0; i < LANES; i++) c += lane_q[i].size();
            chk("lanes_left", 64'(c), 64'd0);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        start_i = 1'b0;
        base_addr_i = '0;
        num_rows_i = '0;
        stall_i = 1'b0;
        for (int r = 0; r < 4096; r++)
            for (int i = 0; i < LANES; i++)
                mem[r][i*DATA_W +: DATA_W] = DATA_W'(((r * 31 + i * 7) % 65535) + 1);
        for (int i = 0; i < LANES; i++) mem[5][i*DATA_W +: DATA_W] = DATA_W'(i + 100);

        #1;
        chk("reset_outputs_zero",
            64'({ub_rd_o, busy_o, done_o, |ub_addr_rd_o, |array_valid_o, |array_data_o}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;

        run(5, 1, 1000, -1, -1, -1);        // single row, done in cycle 35
        run(0, 4, 1000, -1, -1, -1);        // streaming, done in cycle 38
        run(4094, 4, 1000, -1, 10, -1);     // address wrap plus ignored start
        run(10, 3, 2, 4, -1, -1);           // stall cycles 2..4, done in cycle 40
        run(33, 0, 1000, -1, -1, -1);       // zero count
        run(200, 8, 1000, -1, -1, 10);      // reset mid-run

        repeat (2) @(posedge clk);
        #1;
        chk("reset_hold_done", 64'(done_o), 64'd0);
        rst_ni = 1'b1;
        mon_en = 1'b1;
        repeat (40) @(posedge clk);
        run(7, 2, 1000, -1, -1, -1);        // clean run after reset

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
